p1_pool_ctrl: RTL and testbench

Sequencer for pooling layer 1 (2x2 max-pool, stride 2) of the digit-recognition CNN. On a start pulse it walks the 24x24 conv1 output memory through two read ports. Lane 0 covers pooled rows 0-5 and lane 1 covers pooled rows 6-11. It drives the max-unit accumulate controls and issues P1 memory writes (lane 0 to addresses 0-71, lane 1 to 72-143), then reports completion.

---
 rtl/p1_pkg.sv | 22 ++
 rtl/pool_window_counter.sv | 96 +++++++++
 rtl/p1_pool_ctrl.sv | 122 ++++++++++++
 tb/tb_p1_pool_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p1_pkg.sv
// Shared constants and types for the pooling-layer-1 sequencer.
// Lane 1 is lane 0 shifted by half the feature map (conv1) and half the pooled map (P1).
package p1_pkg;

    localparam int IN_DIM            = 24;
    localparam int OUT_DIM           = 12;
    localparam int LANE_ROWS         = 6;
    localparam int P1_LANE1_BASE     = 72;
    localparam int CONV_LANE1_OFFSET = 288;

    typedef logic [9:0] conv1_addr_t;
    typedef logic [7:0] p1_addr_t;
    typedef logic [6:0] win_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } pool_state_t;

endpackage

// File: rtl/pool_window_counter.sv
// Walks the 72 pooling windows of a lane pair, four conv1 reads per window.
// Addresses are built from running row-base and column offsets; no multiplier.
module pool_window_counter
    import p1_pkg::*;
#(
    parameter int IN_DIM  = p1_pkg::IN_DIM,
    parameter int OUT_DIM = p1_pkg::OUT_DIM
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    output conv1_addr_t rd_addr0,
    output conv1_addr_t rd_addr1,
    output logic [1:0]  k,
    output win_idx_t    win_idx,
    output logic        last
);

    logic [2:0]  r_q, r_d;
    logic [3:0]  c_q, c_d;
    logic [1:0]  k_q, k_d;
    win_idx_t    n_q, n_d;
    conv1_addr_t row_base_q, row_base_d;
    conv1_addr_t col2_q, col2_d;
    conv1_addr_t addr0_q, addr0_d;
    conv1_addr_t addr1_q, addr1_d;

    assign last     = (r_q == 3'(LANE_ROWS - 1)) && (c_q == 4'(OUT_DIM - 1)) && (k_q == 2'd3);
    assign rd_addr0 = addr0_q;
    assign rd_addr1 = addr1_q;
    assign k        = k_q;
    assign win_idx  = n_q;

    always_comb begin
        r_d        = r_q;
        c_d        = c_q;
        k_d        = k_q;
        n_d        = n_q;
        row_base_d = row_base_q;
        col2_d     = col2_q;
        addr0_d    = addr0_q;
        addr1_d    = addr1_q;
        if (load || advance) begin
            if (load || last) begin
                r_d        = '0;
                c_d        = '0;
                k_d        = '0;
                n_d        = '0;
                row_base_d = '0;
                col2_d     = '0;
            end else if (k_q != 2'd3) begin
                k_d = k_q + 2'd1;
            end else begin
                k_d = '0;
                n_d = n_q + win_idx_t'(1);
                if (c_q == 4'(OUT_DIM - 1)) begin
                    c_d        = '0;
                    col2_d     = '0;
                    r_d        = r_q + 3'd1;
                    row_base_d = row_base_q + conv1_addr_t'(2 * IN_DIM);
                end else begin
                    c_d    = c_q + 4'd1;
                    col2_d = col2_q + conv1_addr_t'(2);
                end
            end
            // k[1] selects the lower row of the window, k[0] the right column
            addr0_d = row_base_d + col2_d + (k_d[1] ? conv1_addr_t'(IN_DIM) : '0)
                      + conv1_addr_t'(k_d[0]);
            addr1_d = addr0_d + conv1_addr_t'(CONV_LANE1_OFFSET);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            n_q        <= '0;
            row_base_q <= '0;
            col2_q     <= '0;
            addr0_q    <= '0;
            addr1_q    <= '0;
        end else begin
            r_q        <= r_d;
            c_q        <= c_d;
            k_q        <= k_d;
            n_q        <= n_d;
            row_base_q <= row_base_d;
            col2_q     <= col2_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
        end
    end

endmodule

// File: rtl/p1_pool_ctrl.sv
// Pooling-layer-1 sequencer: issues conv1 reads for both lanes, tracks each read
// through the memory latency to drive the max unit, then writes pooled results.
module p1_pool_ctrl
    import p1_pkg::*;
#(
    parameter int IN_DIM  = p1_pkg::IN_DIM,
    parameter int OUT_DIM = p1_pkg::OUT_DIM,
    parameter int RD_LAT  = 1,
    parameter int RD_AW   = 10,
    parameter int WR_AW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [RD_AW-1:0] rd_addr0,
    output logic [RD_AW-1:0] rd_addr1,
    output logic             rd_en,
    output logic             acc_first,
    output logic             acc_en,
    output logic             wr_en,
    output logic [WR_AW-1:0] wr_addr0,
    output logic [WR_AW-1:0] wr_addr1,
    output logic             busy,
    output logic             done
);

    pool_state_t state_q, state_d;

    conv1_addr_t cnt_addr0, cnt_addr1;
    logic [1:0]  cnt_k;
    win_idx_t    cnt_n;
    logic        cnt_last;

    logic [RD_LAT-1:0]      vld_q, vld_d;
    logic [RD_LAT-1:0][1:0] k_pipe_q, k_pipe_d;
    logic [RD_LAT-1:0][6:0] n_pipe_q, n_pipe_d;

    logic     wr_en_q, wr_en_d;
    p1_addr_t wr_addr0_q, wr_addr0_d;
    p1_addr_t wr_addr1_q, wr_addr1_d;

    pool_window_counter #(
        .IN_DIM  (IN_DIM),
        .OUT_DIM (OUT_DIM)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     ((state_q == IDLE) && start),
        .advance  (state_q == RUN),
        .rd_addr0 (cnt_addr0),
        .rd_addr1 (cnt_addr1),
        .k        (cnt_k),
        .win_idx  (cnt_n),
        .last     (cnt_last)
    );

    assign rd_en     = (state_q == RUN);
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign rd_addr0  = RD_AW'(cnt_addr0);
    assign rd_addr1  = RD_AW'(cnt_addr1);
    assign acc_en    = vld_q[RD_LAT-1];
    assign acc_first = vld_q[RD_LAT-1] && (k_pipe_q[RD_LAT-1] == 2'd0);
    assign wr_en     = wr_en_q;
    assign wr_addr0  = WR_AW'(wr_addr0_q);
    assign wr_addr1  = WR_AW'(wr_addr1_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_last) state_d = DRAIN;
            DRAIN:   if (wr_en_q && (wr_addr0_q == p1_addr_t'(P1_LANE1_BASE - 1))) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Window index and k ride alongside each read so the write address never
    // depends on where the live counters have moved to.
    always_comb begin
        vld_d       = vld_q;
        k_pipe_d    = k_pipe_q;
        n_pipe_d    = n_pipe_q;
        vld_d[0]    = (state_q == RUN);
        k_pipe_d[0] = cnt_k;
        n_pipe_d[0] = cnt_n;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]    = vld_q[i-1];
            k_pipe_d[i] = k_pipe_q[i-1];
            n_pipe_d[i] = n_pipe_q[i-1];
        end
        wr_en_d    = vld_q[RD_LAT-1] && (k_pipe_q[RD_LAT-1] == 2'd3);
        wr_addr0_d = wr_addr0_q;
        wr_addr1_d = wr_addr1_q;
        if (wr_en_d) begin
            wr_addr0_d = p1_addr_t'(n_pipe_q[RD_LAT-1]);
            wr_addr1_d = p1_addr_t'(n_pipe_q[RD_LAT-1]) + p1_addr_t'(P1_LANE1_BASE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            vld_q      <= '0;
            k_pipe_q   <= '0;
            n_pipe_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_addr0_q <= '0;
            wr_addr1_q <= p1_addr_t'(P1_LANE1_BASE);
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            k_pipe_q   <= k_pipe_d;
            n_pipe_q   <= n_pipe_d;
            wr_en_q    <= wr_en_d;
            wr_addr0_q <= wr_addr0_d;
            wr_addr1_q <= wr_addr1_d;
        end
    end

endmodule

// File: tb/tb_p1_pool_ctrl.sv
// Bench for p1_pool_ctrl: two instances (read latency 1 and 3) share stimulus and
// are checked against a cycle-numbered reference model plus fixed vector tables.
module tb_p1_pool_ctrl;

    typedef struct packed {
        logic [9:0] rd_addr0;
        logic [9:0] rd_addr1;
        logic       rd_en;
        logic       acc_first;
        logic       acc_en;
        logic       wr_en;
        logic [7:0] wr_addr0;
        logic [7:0] wr_addr1;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        int   d;
        int   t;
        obs_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    logic [9:0] a_rd_addr0, a_rd_addr1, b_rd_addr0, b_rd_addr1;
    logic [7:0] a_wr_addr0, a_wr_addr1, b_wr_addr0, b_wr_addr1;
    logic a_rd_en, a_acc_first, a_acc_en, a_wr_en, a_busy, a_done;
    logic b_rd_en, b_acc_first, b_acc_en, b_wr_en, b_busy, b_done;

    obs_t got0, got1;
    obs_t log0 [0:299];
    obs_t log1 [0:299];
    vec_t vecs[$];

    int checks = 0;
    int failures = 0;
    int m_run [2];
    int m_t [2];
    int m_wn [2];
    obs_t m_exp [2];

    always #5 clk = ~clk;

    p1_pool_ctrl #(
        .IN_DIM (24), .OUT_DIM (12), .RD_LAT (1), .RD_AW (10), .WR_AW (8)
    ) u_dut_a (
        .clk (clk), .reset (reset), .start (start),
        .rd_addr0 (a_rd_addr0), .rd_addr1 (a_rd_addr1), .rd_en (a_rd_en),
        .acc_first (a_acc_first), .acc_en (a_acc_en), .wr_en (a_wr_en),
        .wr_addr0 (a_wr_addr0), .wr_addr1 (a_wr_addr1), .busy (a_busy), .done (a_done)
    );

    p1_pool_ctrl #(
        .IN_DIM (24), .OUT_DIM (12), .RD_LAT (3), .RD_AW (10), .WR_AW (8)
    ) u_dut_b (
        .clk (clk), .reset (reset), .start (start),
        .rd_addr0 (b_rd_addr0), .rd_addr1 (b_rd_addr1), .rd_en (b_rd_en),
        .acc_first (b_acc_first), .acc_en (b_acc_en), .wr_en (b_wr_en),
        .wr_addr0 (b_wr_addr0), .wr_addr1 (b_wr_addr1), .busy (b_busy), .done (b_done)
    );

    assign got0 = {a_rd_addr0, a_rd_addr1, a_rd_en, a_acc_first, a_acc_en, a_wr_en,
                   a_wr_addr0, a_wr_addr1, a_busy, a_done};
    assign got1 = {b_rd_addr0, b_rd_addr1, b_rd_en, b_acc_first, b_acc_en, b_wr_en,
                   b_wr_addr0, b_wr_addr1, b_busy, b_done};

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("rd=%0d/%0d rd_en=%b af=%b ae=%b we=%b wa=%0d/%0d busy=%b done=%b",
                         o.rd_addr0, o.rd_addr1, o.rd_en, o.acc_first, o.acc_en, o.wr_en,
                         o.wr_addr0, o.wr_addr1, o.busy, o.done);
    endfunction

    function automatic vec_t mk(input int d, input int t, input int r0, input int r1,
                                input bit re, input bit af, input bit ae, input bit we,
                                input int w0, input int w1, input bit b, input bit dn);
        vec_t v;
        v.d = d;
        v.t = t;
        v.e.rd_addr0 = 10'(r0);
        v.e.rd_addr1 = 10'(r1);
        v.e.rd_en = re;
        v.e.acc_first = af;
        v.e.acc_en = ae;
        v.e.wr_en = we;
        v.e.wr_addr0 = 8'(w0);
        v.e.wr_addr1 = 8'(w1);
        v.e.busy = b;
        v.e.done = dn;
        return v;
    endfunction

    // Read addresses are don't-care when no read is expected.
    task automatic check_obs(input string name, input int t, input obs_t g, input obs_t e);
        obs_t gm;
        gm = g;
        if (!e.rd_en) begin
            gm.rd_addr0 = '0;
            gm.rd_addr1 = '0;
        end
        checks++;
        if (gm !== e) begin
            failures++;
            $display("FAIL %s t=%0d got %s want %s", name, t, fmt(g), fmt(e));
        end
    endtask

    task automatic check_int(input string name, input int g, input int e);
        checks++;
        if (g != e) begin
            failures++;
            $display("FAIL %s got %0d want %0d", name, g, e);
        end
    endtask

    // Reference: outputs follow from the cycle number t since the start edge.
    task automatic model_update(input int d, input logic rv, input logic sv);
        int l, t, i, n, k, r, c, a, j;
        obs_t e;
        l = lat_of(d);
        if (rv) begin
            m_run[d] = 0;
            m_t[d] = 0;
            m_wn[d] = -1;
        end else if (m_run[d] == 0) begin
            if (sv) begin
                m_run[d] = 1;
                m_t[d] = 1;
            end
        end else if (m_t[d] == 290 + l) begin
            m_run[d] = 0;
            m_t[d] = 0;
        end else begin
            m_t[d]++;
        end
        e = '0;
        if (m_run[d] != 0) begin
            t = m_t[d];
            if (t >= 1 && t <= 288) begin
                i = t - 1;
                n = i / 4;
                k = i % 4;
                r = n / 12;
                c = n % 12;
                a = (2 * r + k / 2) * 24 + 2 * c + k % 2;
                e.rd_en = 1'b1;
                e.rd_addr0 = 10'(a);
                e.rd_addr1 = 10'(a + 288);
            end
            if (t >= 1 + l && t <= 288 + l) begin
                e.acc_en = 1'b1;
                e.acc_first = ((t - 1 - l) % 4) == 0;
            end
            j = t - 5 - l;
            if (j >= 0 && (j % 4) == 0 && (j / 4) <= 71) begin
                e.wr_en = 1'b1;
                m_wn[d] = j / 4;
            end
            e.busy = (t <= 289 + l);
            e.done = (t == 290 + l);
        end
        e.wr_addr0 = (m_wn[d] < 0) ? 8'd0 : 8'(m_wn[d]);
        e.wr_addr1 = (m_wn[d] < 0) ? 8'd72 : 8'(72 + m_wn[d]);
        m_exp[d] = e;
    endtask

    task automatic step(input logic rv, input logic sv);
        reset = rv;
        start = sv;
        @(posedge clk);
        #1;
        model_update(0, rv, sv);
        model_update(1, rv, sv);
        check_obs("model_L1", m_t[0], got0, m_exp[0]);
        check_obs("model_L3", m_t[1], got1, m_exp[1]);
    endtask

    task automatic run_logged();
        step(1'b0, 1'b1);
        log0[1] = got0;
        log1[1] = got1;
        for (int t = 2; t <= 296; t++) begin
            step(1'b0, 1'b0);
            log0[t] = got0;
            log1[t] = got1;
        end
    endtask

    task automatic apply_table(input string tag);
        int n_rd [2];
        int n_acc [2];
        int n_wr [2];
        int n_done [2];
        obs_t o;
        foreach (vecs[i]) begin
            o = (vecs[i].d == 0) ? log0[vecs[i].t] : log1[vecs[i].t];
            check_obs($sformatf("%s_vec%0d_L%0d", tag, i, lat_of(vecs[i].d)), vecs[i].t, o,
                      vecs[i].e);
        end
        n_rd = '{0, 0};
        n_acc = '{0, 0};
        n_wr = '{0, 0};
        n_done = '{0, 0};
        for (int t = 1; t <= 296; t++) begin
            n_rd[0] += int'(log0[t].rd_en);
            n_rd[1] += int'(log1[t].rd_en);
            n_acc[0] += int'(log0[t].acc_en);
            n_acc[1] += int'(log1[t].acc_en);
            n_wr[0] += int'(log0[t].wr_en);
            n_wr[1] += int'(log1[t].wr_en);
            n_done[0] += int'(log0[t].done);
            n_done[1] += int'(log1[t].done);
        end
        for (int d = 0; d < 2; d++) begin
            check_int($sformatf("%s_rd_count_L%0d", tag, lat_of(d)), n_rd[d], 288);
            check_int($sformatf("%s_acc_count_L%0d", tag, lat_of(d)), n_acc[d], 288);
            check_int($sformatf("%s_wr_count_L%0d", tag, lat_of(d)), n_wr[d], 72);
            check_int($sformatf("%s_done_count_L%0d", tag, lat_of(d)), n_done[d], 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rd [2];
        int n_wr [2];
        bit hold;
        logic rv, sv;
        obs_t e_abort;

        m_run = '{0, 0};
        m_t = '{0, 0};
        m_wn = '{-1, -1};

        // RD_LAT=1 instance
        vecs.push_back(mk(0,   1,   0, 288, 1, 0, 0, 0,  0,  72, 1, 0));
        vecs.push_back(mk(0,   2,   1, 289, 1, 1, 1, 0,  0,  72, 1, 0));
        vecs.push_back(mk(0,   3,  24, 312, 1, 0, 1, 0,  0,  72, 1, 0));
        vecs.push_back(mk(0,   4,  25, 313, 1, 0, 1, 0,  0,  72, 1, 0));
        vecs.push_back(mk(0,   5,   2, 290, 1, 0, 1, 0,  0,  72, 1, 0));
        vecs.push_back(mk(0,   6,   3, 291, 1, 1, 1, 1,  0,  72, 1, 0));
        vecs.push_back(mk(0,   7,  26, 314, 1, 0, 1, 0,  0,  72, 1, 0));
        vecs.push_back(mk(0,  45,  22, 310, 1, 0, 1, 0,  9,  81, 1, 0));
        vecs.push_back(mk(0,  46,  23, 311, 1, 1, 1, 1, 10,  82, 1, 0));
        vecs.push_back(mk(0,  49,  48, 336, 1, 0, 1, 0, 10,  82, 1, 0));
        vecs.push_back(mk(0,  50,  49, 337, 1, 1, 1, 1, 11,  83, 1, 0));
        vecs.push_back(mk(0,  52,  73, 361, 1, 0, 1, 0, 11,  83, 1, 0));
        vecs.push_back(mk(0, 285, 262, 550, 1, 0, 1, 0, 69, 141, 1, 0));
        vecs.push_back(mk(0, 286, 263, 551, 1, 1, 1, 1, 70, 142, 1, 0));
        vecs.push_back(mk(0, 288, 287, 575, 1, 0, 1, 0, 70, 142, 1, 0));
        vecs.push_back(mk(0, 289,   0,   0, 0, 0, 1, 0, 70, 142, 1, 0));
        vecs.push_back(mk(0, 290,   0,   0, 0, 0, 0, 1, 71, 143, 1, 0));
        vecs.push_back(mk(0, 291,   0,   0, 0, 0, 0, 0, 71, 143, 0, 1));
        vecs.push_back(mk(0, 292,   0,   0, 0, 0, 0, 0, 71, 143, 0, 0));
        // RD_LAT=3 instance
        vecs.push_back(mk(1,   1,   0, 288, 1, 0, 0, 0,  0,  72, 1, 0));
        vecs.push_back(mk(1,   3,  24, 312, 1, 0, 0, 0,  0,  72, 1, 0));
        vecs.push_back(mk(1,   4,  25, 313, 1, 1, 1, 0,  0,  72, 1, 0));
        vecs.push_back(mk(1,   7,  26, 314, 1, 0, 1, 0,  0,  72, 1, 0));
        vecs.push_back(mk(1,   8,  27, 315, 1, 1, 1, 1,  0,  72, 1, 0));
        vecs.push_back(mk(1, 288, 287, 575, 1, 1, 1, 1, 70, 142, 1, 0));
        vecs.push_back(mk(1, 291,   0,   0, 0, 0, 1, 0, 70, 142, 1, 0));
        vecs.push_back(mk(1, 292,   0,   0, 0, 0, 0, 1, 71, 143, 1, 0));
        vecs.push_back(mk(1, 293,   0,   0, 0, 0, 0, 0, 71, 143, 0, 1));
        vecs.push_back(mk(1, 294,   0,   0, 0, 0, 0, 0, 71, 143, 0, 0));

        // Reset state, then a single-pulse run.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        run_logged();
        apply_table("run1");

        // start held through the whole run, including the DONE cycle of the L1 instance.
        step(1'b1, 1'b0);
        n_rd = '{0, 0};
        n_wr = '{0, 0};
        for (int t = 0; t <= 291; t++) begin
            step(1'b0, 1'b1);
            n_rd[0] += int'(got0.rd_en);
            n_rd[1] += int'(got1.rd_en);
            n_wr[0] += int'(got0.wr_en);
            n_wr[1] += int'(got1.wr_en);
        end
        for (int t = 0; t < 120; t++) begin
            step(1'b0, 1'b0);
            n_rd[0] += int'(got0.rd_en);
            n_rd[1] += int'(got1.rd_en);
            n_wr[0] += int'(got0.wr_en);
            n_wr[1] += int'(got1.wr_en);
        end
        check_int("hold_rd_count_L1", n_rd[0], 288);
        check_int("hold_rd_count_L3", n_rd[1], 288);
        check_int("hold_wr_count_L1", n_wr[0], 72);
        check_int("hold_wr_count_L3", n_wr[1], 72);

        // Abort with reset at cycle 100, then rerun and expect the first run exactly.
        step(1'b0, 1'b1);
        for (int t = 2; t <= 100; t++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        e_abort = '0;
        e_abort.wr_addr1 = 8'd72;
        check_obs("abort_L1", 101, got0, e_abort);
        check_obs("abort_L3", 101, got1, e_abort);
        step(1'b0, 1'b0);
        check_obs("abort_idle_L1", 102, got0, e_abort);
        check_obs("abort_idle_L3", 102, got1, e_abort);
        step(1'b0, 1'b0);
        run_logged();
        apply_table("run2");

        // Randomized start pulses, held starts and occasional resets.
        hold = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 149) == 0) hold = ~hold;
            rv = ($urandom_range(0, 399) == 0);
            sv = hold ? 1'b1 : ($urandom_range(0, 19) == 0);
            step(rv, sv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
